alsaqr_valrdy_to_credit: RTL and testbench

- Converts an upstream valid/ready stream into the credit-based (valid/yummy) NoC link protocol. This is the transmit-side partner of the credit-to-valrdy receiver.
- Incoming flits are buffered in a small FIFO. A flit is launched on the NoC only while a downstream credit is available. Each yummy pulse from downstream returns one credit.
- Sits between an AXI-side adapter and an OpenPiton NoC input port.

---
 rtl/alsaqr_valrdy_to_credit.sv | 104 ++++++++++
 tb/tb_alsaqr_valrdy_to_credit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alsaqr_valrdy_to_credit.sv
// ============================================================================
// Module   : alsaqr_valrdy_to_credit
// Purpose  : Buffers a valid/ready stream and transmits it over a credit-based
//            (valid/yummy) NoC link.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alsaqr_valrdy_to_credit #(
  parameter  int DATA_WIDTH  = 64,
  parameter  int BUF_DEPTH   = 4,
  parameter  int MAX_CREDITS = 8,
  localparam int CW          = $clog2(MAX_CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  yummy_out,
  output logic [CW-1:0]         credits,
  output logic                  credit_err
);

  localparam int              PW   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PW:0]     FULL = (PW + 1)'(BUF_DEPTH);
  localparam logic [CW-1:0]   CMAX = CW'(MAX_CREDITS);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q,  count_d;
  logic [CW-1:0]         credits_q, credits_d;
  logic                  err_q, err_d;
  logic                  vout_q, vout_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  logic                  push;
  logic                  send;

  // Acceptance depends only on registered occupancy, never on valid_in.
  assign ready_in = reset & (count_q != FULL);
  assign push     = valid_in & ready_in;
  assign send     = (count_q != '0) & (credits_q != '0);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + (PW + 1)'(push) - (PW + 1)'(send);
    credits_d = credits_q;
    err_d     = err_q;
    vout_d    = send;
    dout_d    = dout_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (send) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      dout_d   = mem[rd_ptr_q];
    end

    // A returned credit with the counter already full is a protocol error.
    if (send && !yummy_out) begin
      credits_d = credits_q - CW'(1);
    end else if (!send && yummy_out) begin
      if (credits_q == CMAX) err_d = 1'b1;
      else                   credits_d = credits_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      credits_q <= CMAX;
      err_q     <= 1'b0;
      vout_q    <= 1'b0;
      dout_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      credits_q <= credits_d;
      err_q     <= err_d;
      vout_q    <= vout_d;
      dout_q    <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= data_in;
  end

  assign data_out   = dout_q;
  assign valid_out  = vout_q;
  assign credits    = credits_q;
  assign credit_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_alsaqr_valrdy_to_credit.sv
// ============================================================================
// Module   : tb_alsaqr_valrdy_to_credit
// Purpose  : Directed scoreboard bench for the valid/ready to credit converter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alsaqr_valrdy_to_credit;

  localparam int DW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          ready_in;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          yummy_out;
  logic [CW-1:0] credits;
  logic          credit_err;

  int n_cmp   = 0;
  int n_err   = 0;
  int n_pulse = 0;
  logic [DW-1:0] sb [$];

  alsaqr_valrdy_to_credit #(
    .DATA_WIDTH (64),
    .BUF_DEPTH  (4),
    .MAX_CREDITS(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .yummy_out (yummy_out),
    .credits   (credits),
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every flit leaving the block must match the oldest accepted flit.
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      n_pulse++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL spurious_send: observed data %0h expected no flit", data_out);
      end else begin
        chk("data_out", data_out, sb.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic y);
    valid_in  = v;
    data_in   = d;
    yummy_out = y;
    if (v && ready_in === 1'b1) sb.push_back(d);
    cyc();
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    valid_in  = 1'b0;
    yummy_out = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  int p0;

  initial begin
    reset     = 1'b0;
    valid_in  = 1'b0;
    yummy_out = 1'b0;
    data_in   = '0;

    // Reset then idle
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_valid_out", valid_out, 0);
      chk("rst_ready_in", ready_in, 0);
      chk("rst_credits", credits, 8);
      chk("rst_credit_err", credit_err, 0);
      chk("rst_data_out", data_out, 0);
    end
    reset = 1'b1;
    cyc();
    chk("idle_credits", credits, 8);
    chk("idle_ready_in", ready_in, 1);
    chk("idle_valid_out", valid_out, 0);

    // Single flit: two-cycle latency, one credit consumed
    drive(1'b1, 64'hA5, 1'b0);
    chk("single_n1_valid", valid_out, 0);
    drive(1'b0, 64'h0, 1'b0);
    chk("single_n2_valid", valid_out, 1);
    chk("single_n2_data", data_out, 64'hA5);
    chk("single_credits", credits, 7);
    drive(1'b0, 64'h0, 1'b0);
    chk("single_n3_valid", valid_out, 0);

    // Credit exhaustion with 12 back-to-back flits
    do_reset();
    p0 = n_pulse;
    for (int i = 0; i < 12; i++) drive(1'b1, 64'h100 + 64'(i), 1'b0);
    valid_in = 1'b0;
    chk("exh_ready_full", ready_in, 0);
    drive(1'b0, 64'h0, 1'b0);
    drive(1'b0, 64'h0, 1'b0);
    chk("exh_pulses", n_pulse - p0, 8);
    chk("exh_credits", credits, 0);
    chk("exh_fifo_held", sb.size(), 4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 64'h0, 1'b1);
      drive(1'b0, 64'h0, 1'b0);
    end
    drive(1'b0, 64'h0, 1'b0);
    chk("exh_drain_pulses", n_pulse - p0, 12);
    chk("exh_drain_ready", ready_in, 1);
    chk("exh_drain_credits", credits, 0);

    // Simultaneous send and credit return at credits=3
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 64'h200 + 64'(i), 1'b0);
    drive(1'b0, 64'h0, 1'b0);
    drive(1'b0, 64'h0, 1'b0);
    chk("sim_start_credits", credits, 3);
    drive(1'b1, 64'h300, 1'b0);
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 64'h300 + 64'(i), 1'b1);
      chk("sim_credits", credits, 3);
      chk("sim_valid", valid_out, 1);
    end
    drive(1'b0, 64'h0, 1'b1);
    chk("sim_tail_credits", credits, 3);
    chk("sim_tail_valid", valid_out, 1);
    drive(1'b0, 64'h0, 1'b0);
    chk("sim_end_valid", valid_out, 0);
    chk("sim_end_credits", credits, 3);

    // Full FIFO with one credit: push blocked, then accepted after the pop
    do_reset();
    for (int i = 0; i < 8; i++) drive(1'b1, 64'h400 + 64'(i), 1'b0);
    drive(1'b0, 64'h0, 1'b0);
    drive(1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 64'h500 + 64'(i), 1'b0);
    drive(1'b0, 64'h0, 1'b1);
    chk("full_credits", credits, 1);
    chk("full_ready_blocked", ready_in, 0);
    p0 = n_pulse;
    drive(1'b1, 64'h5A5A, 1'b0);
    chk("full_ready_after_pop", ready_in, 1);
    drive(1'b1, 64'h5A5A, 1'b0);
    valid_in = 1'b0;
    chk("full_ready_refull", ready_in, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 64'h0, 1'b1);
      drive(1'b0, 64'h0, 1'b0);
    end
    drive(1'b0, 64'h0, 1'b0);
    chk("full_pulses", n_pulse - p0, 5);
    chk("full_sb_empty", sb.size(), 0);

    // Credit overflow is sticky until reset
    do_reset();
    chk("ovf_pre_err", credit_err, 0);
    drive(1'b0, 64'h0, 1'b1);
    chk("ovf_credits", credits, 8);
    chk("ovf_err", credit_err, 1);
    drive(1'b0, 64'h0, 1'b0);
    drive(1'b0, 64'h0, 1'b0);
    chk("ovf_err_sticky", credit_err, 1);
    reset = 1'b0;
    cyc();
    chk("ovf_err_cleared", credit_err, 0);
    reset = 1'b1;
    cyc();
    chk("ovf_err_after_rel", credit_err, 0);
    chk("ovf_credits_after_rel", credits, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
